// File: rtl/upower_pkg.sv
// Shared types and widths for the uPower instruction-memory loader.
package upower_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned BYTE_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Big-endian byte-to-word assembler: collects four bytes MSB first and
// flags the cycle in which the fourth byte is pushed.
module byte_word_assembler
    import upower_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  logic [BYTE_W-1:0]  byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_valid
);

    logic [1:0]                idx_q, idx_d;
    logic [INSTR_W-BYTE_W-1:0] shift_q, shift_d;

    // The word is presented combinationally so the 4th byte needs no extra cycle.
    assign word       = {shift_q, byte_in};
    assign word_valid = push && !clear && (idx_q == 2'd3);

    // Next byte index and shift contents.
    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clear) begin
            idx_d = '0;
        end else if (push) begin
            idx_d   = idx_q + 2'd1;
            shift_d = {shift_q[INSTR_W-2*BYTE_W-1:0], byte_in};
        end
    end

    // Byte index and shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory program loader: length header, big-endian words,
// XOR checksum; holds the core in reset until a good load completes.
module imem_loader
    import upower_pkg::*;
#(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    parameter int unsigned          MAX_WORDS = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [BYTE_W-1:0]  byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_hold,
    output logic               load_done,
    output logic               load_error,
    output logic [ADDR_W-1:0]  words_loaded
);

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  len_q, len_d;
    logic [INSTR_W-1:0]  words_acc_q, words_acc_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0]  imem_wdata_q, imem_wdata_d;
    logic [ADDR_W-1:0]   words_loaded_q, words_loaded_d;

    logic                start_ok;
    logic                accept;
    logic [INSTR_W-1:0]  asm_word;
    logic                asm_valid;

    assign byte_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign accept     = byte_valid && byte_ready;
    assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));

    // Same assembler serves the length header and the data words.
    byte_word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (start_ok),
        .push       (accept && ((state_q == LEN) || (state_q == DATA))),
        .byte_in    (byte_in),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    // Next-state, checksum and write-strobe generation.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        words_acc_d    = words_acc_q;
        csum_d         = csum_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        words_loaded_d = words_loaded_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d        = LEN;
                    len_d          = '0;
                    words_acc_d    = '0;
                    csum_d         = '0;
                    words_loaded_d = '0;
                    imem_addr_d    = BASE_ADDR;
                end
            end
            LEN: begin
                if (asm_valid) begin
                    len_d = asm_word;
                    if (asm_word > INSTR_W'(MAX_WORDS)) state_d = ERROR;
                    else if (asm_word == '0)            state_d = CSUM;
                    else                                state_d = DATA;
                end
            end
            DATA: begin
                if (accept) csum_d = csum_q ^ byte_in;
                // words_acc tracks accepted words so CSUM is entered without
                // waiting for the registered strobe to land.
                if (asm_valid) begin
                    imem_we_d      = 1'b1;
                    imem_wdata_d   = asm_word;
                    imem_addr_d    = BASE_ADDR + words_loaded_q;
                    words_loaded_d = words_loaded_q + ADDR_W'(1);
                    words_acc_d    = words_acc_q + INSTR_W'(1);
                    if (words_acc_q + INSTR_W'(1) == len_q) state_d = CSUM;
                end
            end
            CSUM: begin
                if (accept) state_d = (byte_in == csum_q) ? DONE : ERROR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Loader state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            words_acc_q    <= '0;
            csum_q         <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= BASE_ADDR;
            imem_wdata_q   <= '0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            words_acc_q    <= words_acc_d;
            csum_q         <= csum_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign words_loaded = words_loaded_q;
    assign load_done    = (state_q == DONE);
    assign load_error   = (state_q == ERROR);
    assign core_hold    = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed vector table, hand-written
// reset / idle sequences, and randomized loads against a stream-level model.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_error;
    logic [31:0] words_loaded;

    always #5 clock = ~clock;

    imem_loader #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0),
        .MAX_WORDS (1024)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] wq[$];   // observed writes {addr, data}

    always @(negedge clock) begin
        if (imem_we) wq.push_back({imem_addr, imem_wdata});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one load. gap: 0 = valid always, 1 = valid every other cycle
    // (with a start pulse while DATA bytes are flowing), 2 = random valid.
    // n_send limits how many bytes are offered. Returns done/error sampled
    // right after the final byte transfers.
    task automatic send(input logic [7:0] s[$], input int gap, input int n_send,
                        output logic fin_done, output logic fin_err);
        int  i   = 0;
        int  cyc = 0;
        bit  tog = 1'b0;
        logic v, xfer;
        wq.delete();
        @(negedge clock);
        start = 1'b1; byte_valid = 1'b0;
        @(negedge clock);
        start = 1'b0;
        while (i < n_send && cyc < 2000) begin
            cyc++;
            v   = (gap == 0) ? 1'b1 : (gap == 1) ? tog : 1'($urandom % 2);
            tog = !tog;
            start      = (gap == 1) && (i == 6);
            byte_valid = v;
            byte_in    = v ? s[i] : 8'($urandom);
            xfer       = v && byte_ready;
            @(negedge clock);
            if (xfer) i++;
        end
        if (cyc >= 2000) chk("timeout_bytes", 64'(i), 64'(n_send));
        byte_valid = 1'b0;
        start      = 1'b0;
        fin_done   = load_done;
        fin_err    = load_error;
    endtask

    task automatic check_result(input string tag, input logic [63:0] exp_w[$],
                                input logic exp_done, input logic exp_err,
                                input logic fin_done, input logic fin_err);
        chk({tag, ".done_now"}, 64'(fin_done), 64'(exp_done));
        chk({tag, ".err_now"},  64'(fin_err),  64'(exp_err));
        repeat (3) @(negedge clock);
        chk({tag, ".nwrites"}, 64'(wq.size()), 64'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && k < wq.size(); k++)
            chk($sformatf("%s.write%0d", tag, k), wq[k], exp_w[k]);
        chk({tag, ".load_done"},  64'(load_done),  64'(exp_done));
        chk({tag, ".load_error"}, 64'(load_error), 64'(exp_err));
        chk({tag, ".core_hold"},  64'(core_hold),  64'(!exp_done));
        chk({tag, ".words"},      64'(words_loaded), 64'(exp_w.size()));
        chk({tag, ".ready_idle"}, 64'(byte_ready), 64'(0));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".ready"}, 64'(byte_ready), 64'(0));
        chk({tag, ".we"},    64'(imem_we),    64'(0));
        chk({tag, ".addr"},  64'(imem_addr),  64'(0));
        chk({tag, ".wdata"}, 64'(imem_wdata), 64'(0));
        chk({tag, ".hold"},  64'(core_hold),  64'(1));
        chk({tag, ".done"},  64'(load_done),  64'(0));
        chk({tag, ".err"},   64'(load_error), 64'(0));
        chk({tag, ".words"}, 64'(words_loaded), 64'(0));
    endtask

    typedef struct {
        string        name;
        logic [127:0] bytes;   // left-aligned stream
        int           nb;
        int           gap;
        int           nw;
        logic [31:0]  w0, w1;
        logic         done, err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0]  s[$];
        logic [63:0] ew[$];
        logic        fd, fe;

        vecs[0] = '{"nominal", {104'h00000002_38200005_7C221214_45, 24'h0}, 13, 0, 2,
                    32'h38200005, 32'h7C221214, 1'b1, 1'b0};
        vecs[1] = '{"bad_csum", {104'h00000002_38200005_7C221214_44, 24'h0}, 13, 0, 2,
                    32'h38200005, 32'h7C221214, 1'b0, 1'b1};
        vecs[2] = '{"zero_len", {40'h00000000_00, 88'h0}, 5, 0, 0,
                    32'h0, 32'h0, 1'b1, 1'b0};
        vecs[3] = '{"oversize", {32'h00000401, 96'h0}, 4, 0, 0,
                    32'h0, 32'h0, 1'b0, 1'b1};
        vecs[4] = '{"gaps", {104'h00000002_38200005_7C221214_45, 24'h0}, 13, 1, 2,
                    32'h38200005, 32'h7C221214, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = '0;
        #2;
        check_reset_values("por");
        @(negedge clock); @(negedge clock);
        reset = 1'b0;

        // Bytes offered in IDLE must not be taken.
        byte_valid = 1'b1; byte_in = 8'hAA;
        repeat (3) begin
            @(negedge clock);
            chk("idle_ready", 64'(byte_ready), 64'(0));
        end
        byte_valid = 1'b0;

        for (int v = 0; v < 5; v++) begin
            s.delete(); ew.delete();
            for (int k = 0; k < vecs[v].nb; k++) s.push_back(vecs[v].bytes[127-8*k -: 8]);
            if (vecs[v].nw > 0) ew.push_back({32'd0, vecs[v].w0});
            if (vecs[v].nw > 1) ew.push_back({32'd1, vecs[v].w1});
            send(s, vecs[v].gap, vecs[v].nb, fd, fe);
            check_result(vecs[v].name, ew, vecs[v].done, vecs[v].err, fd, fe);
        end

        // Async reset after the 6th byte, away from any clock edge.
        s.delete();
        for (int k = 0; k < 13; k++) s.push_back(vecs[0].bytes[127-8*k -: 8]);
        send(s, 0, 6, fd, fe);
        chk("pre_reset_ready", 64'(byte_ready), 64'(1));
        #2 reset = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge clock);
        reset = 1'b0;
        ew.delete();
        ew.push_back({32'd0, 32'h38200005});
        ew.push_back({32'd1, 32'h7C221214});
        send(s, 0, 13, fd, fe);
        check_result("after_rst", ew, 1'b1, 1'b0, fd, fe);

        // Randomized loads against the stream-level model.
        for (int r = 0; r < 25; r++) begin
            int unsigned n;
            logic [7:0]  cs;
            logic [31:0] w;
            bit          bad, over;
            s.delete(); ew.delete();
            over = ($urandom % 8) == 0;
            n    = over ? 1025 + $urandom_range(0, 5000) : $urandom_range(0, 5);
            for (int k = 3; k >= 0; k--) s.push_back(8'(n >> (8*k)));
            cs  = 8'h00;
            bad = ($urandom % 4) == 0;
            if (!over) begin
                for (int unsigned i = 0; i < n; i++) begin
                    w = $urandom;
                    for (int k = 3; k >= 0; k--) begin
                        s.push_back(8'(w >> (8*k)));
                        cs = cs ^ 8'(w >> (8*k));
                    end
                    ew.push_back({32'(i), w});
                end
                s.push_back(bad ? cs ^ 8'($urandom_range(1, 255)) : cs);
            end
            send(s, 2, s.size(), fd, fe);
            check_result($sformatf("rand%0d", r), ew, !over && !bad, over || bad, fd, fe);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
